// File: rtl/jam_pkg.sv
// Shared constants and state encoding for the job-assignment cost table.
// No logic; widths and the FSM state type used by jam_cost_table.
// Optional checksum feature is selected by JAM_COST_CHECKSUM_EN in the top.
package jam_pkg;

  localparam int N_JOBS = 8;   // workers = jobs
  localparam int COST_W = 7;   // cost entry width
  localparam int IDX_W  = 3;   // worker / job index width
  localparam int CNT_W  = 7;   // load counter, holds 0..64
  localparam int ADDR_W = 2 * IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    SERVE = 2'd3
  } state_t;

endpackage

// File: rtl/jam_cost_mem.sv
// Cost storage: register array, one synchronous write port, one async read port.
// Latency: write visible on rd_dat the cycle after the write edge; read is 0-cycle.
// Backpressure: none; the caller gates we.
module jam_cost_mem #(
  parameter int ADDR_W = 6,
  parameter int DAT_W  = 7
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DAT_W-1:0]  wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DAT_W-1:0]  rd_dat
);

  // Contents are left unreset; the top masks reads until a full load lands.
  logic [DAT_W-1:0] mem [2**ADDR_W];

  // Single write port, row-major address supplied by the load counter.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/jam_cost_table.sv
// Cost-table responder: loads an 8x8 cost matrix over valid/ready, then serves (W,J) lookups.
// Latency: Cost is a 0-cycle mux of the stored table; TableReady rises the cycle after the last accepted word.
// Backpressure: LD_READY high only while loading (or awaiting checksum with JAM_COST_CHECKSUM_EN); low in IDLE/SERVE.
module jam_cost_table #(
  parameter int N_JOBS = jam_pkg::N_JOBS,
  parameter int COST_W = jam_pkg::COST_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      LD_VALID,
  input  logic [COST_W-1:0]         LD_DATA,
  output logic                      LD_READY,
  input  logic                      Clear,
  input  logic [jam_pkg::IDX_W-1:0] W,
  input  logic [jam_pkg::IDX_W-1:0] J,
  output logic [COST_W-1:0]         Cost,
  output logic                      TableReady,
  output logic                      LdErr
);

  import jam_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_JOBS * N_JOBS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              we;
  logic [COST_W-1:0] rd_dat;

`ifdef JAM_COST_CHECKSUM_EN
  logic [COST_W-1:0] acc_q, acc_d;
  logic              ld_err_q, ld_err_d;
`endif

  // State, counter and checksum registers; reset discards any partial load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
`ifdef JAM_COST_CHECKSUM_EN
      acc_q    <= '0;
      ld_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
`ifdef JAM_COST_CHECKSUM_EN
      acc_q    <= acc_d;
      ld_err_q <= ld_err_d;
`endif
    end
  end

  // Next-state, counter update, write enable and load handshake.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we       = 1'b0;
    LD_READY = 1'b0;
`ifdef JAM_COST_CHECKSUM_EN
    acc_d    = acc_q;
    ld_err_d = ld_err_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = LOAD;
      end
      LOAD: begin
        LD_READY = 1'b1;
        if (LD_VALID) begin
          we    = 1'b1;
          idx_d = idx_q + 1'b1;
`ifdef JAM_COST_CHECKSUM_EN
          acc_d = acc_q + LD_DATA;
          if (idx_q == '0) begin
            ld_err_d = 1'b0;
          end
          if (idx_q == LAST_IDX) begin
            state_d = CHECK;
          end
`else
          if (idx_q == LAST_IDX) begin
            state_d = SERVE;
          end
`endif
        end
      end
      CHECK: begin
`ifdef JAM_COST_CHECKSUM_EN
        LD_READY = 1'b1;
        if (LD_VALID) begin
          if (LD_DATA == acc_q) begin
            state_d = SERVE;
          end else begin
            ld_err_d = 1'b1;
            idx_d    = '0;
            acc_d    = '0;
            state_d  = LOAD;
          end
        end
`else
        state_d = LOAD;
`endif
      end
      SERVE: begin
        state_d = SERVE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Clear wins over a same-cycle transfer: word neither written nor counted.
    if (Clear) begin
      state_d = LOAD;
      idx_d   = '0;
      we      = 1'b0;
`ifdef JAM_COST_CHECKSUM_EN
      acc_d    = '0;
      ld_err_d = 1'b0;
`endif
    end
  end

  jam_cost_mem #(
    .ADDR_W (ADDR_W),
    .DAT_W  (COST_W)
  ) u_mem (
    .CLK     (CLK),
    .we      (we),
    .wr_addr (idx_q[ADDR_W-1:0]),
    .wr_dat  (LD_DATA),
    .rd_addr ({W, J}),
    .rd_dat  (rd_dat)
  );

  assign TableReady = (state_q == SERVE);
  assign Cost       = TableReady ? rd_dat : '0;

`ifdef JAM_COST_CHECKSUM_EN
  assign LdErr = ld_err_q;
`else
  assign LdErr = 1'b0;
`endif

endmodule

// File: doc/jam_cost_table.md
# jam_cost_table

Cost-table responder for the job-assignment engine. It stores the 8×8 worker/job cost matrix, loaded once over a valid/ready stream. It then answers the engine's `(W, J)` lookups with a zero-latency `Cost`, which is the timing the engine's accumulate state relies on. It replaces the behavioural cost ROM in the test harness with synthesizable storage and a load handshake.

## Interface
Parameters:
- `N_JOBS`, 8: workers = jobs; matrix is `N_JOBS`×`N_JOBS`, indices 3 bits.
- `COST_W`, 7: cost entry width.

Ports:
- `CLK`: input, 1; single clock, all state on rising edge.
- `RST`: input, 1; asynchronous, active-low reset.
- `LD_VALID`: input, 1; load word present on `LD_DATA`.
- `LD_DATA`: input, `COST_W`; cost entry (or checksum word, see Configuration).
- `LD_READY`: output, 1; block accepts a load word this cycle.
- `Clear`: input, 1; synchronous restart of loading.
- `W`: input, 3; worker index from the engine.
- `J`: input, 3; job index from the engine.
- `Cost`: output, `COST_W`; cost of worker `W` on job `J`.
- `TableReady`: output, 1; full matrix loaded and accepted.
- `LdErr`: output, 1; checksum failure (tied 0 without the macro).

## Operation
- FSM states:
  - `IDLE`: the reset state. It goes unconditionally to `LOAD` on the next cycle.
  - `LOAD`: `LD_READY`=1.
  - `CHECK`: exists only with the macro; `LD_READY`=1.
  - `SERVE`: `LD_READY`=0, `TableReady`=1.
- Transfer occurs when `LD_VALID && LD_READY` is high at a rising edge. No other cycle changes the table or the counter.
- Load order is row-major: transfer k (0..63) writes entry `[W=k/8][J=k%8]`. The 7-bit counter `idx` holds 0..64 and increments by 1 per transfer.
- `LOAD` → `SERVE` (or `CHECK`) on the edge that accepts transfer 63.
- `SERVE` is held until `Clear` or reset. Lookups are combinational: `Cost = table[{W,J}]` while `TableReady`=1, else `Cost`=0.
- `Clear` in any state:
  - Sets `idx`=0, `TableReady`=0, `LdErr`=0; next state is `LOAD`.
  - Table contents are retained but invisible until reload.
  - `Clear` has priority over a simultaneous transfer; that word is not written and not counted.
- `LD_DATA` is stored unmodified; there is no saturation. `idx` cannot exceed 64 because `LD_READY` drops after transfer 63.

## Timing
- Reset values: `LD_READY`=0, `TableReady`=0, `LdErr`=0, `Cost`=0, state `IDLE`, `idx`=0, checksum accumulator 0. Table contents are undefined, which is acceptable because `Cost` is gated.
- `LD_READY` is 1 from the second rising edge after `RST` deasserts.
- Without the macro, `TableReady` rises the cycle after the edge that accepts transfer 63. Minimum time from reset release to `TableReady` is 65 cycles.
- `Cost` has 0-cycle latency from `W`/`J`; it is a pure mux of the registered table.
- A write to entry X on edge N is visible on `Cost` from the cycle after edge N.
- `Clear` takes effect on its edge: `TableReady`=0 and `LD_READY`=1 from the next cycle.
- Reset asserted mid-load returns all outputs to reset values immediately (asynchronously). A partial load is discarded.

## Configuration
- Macro `JAM_COST_CHECKSUM_EN`.
- When defined:
  - The accumulator sums the 64 entries mod 2^`COST_W`.
  - After transfer 63 the FSM enters `CHECK` and accepts one more word (transfer 64) as the checksum.
  - On a match, go to `SERVE`; `TableReady` rises the cycle after.
  - On a mismatch, set `LdErr`=1, clear `idx` and the accumulator, and return to `LOAD`; `TableReady` stays 0.
  - `LdErr` clears on `Clear`, on reset, or on the first transfer of the next load.
- When undefined: no `CHECK` state, no accumulator, and `LdErr` is tied to 0.

## Structure
- Shared package `jam_pkg`: `N_JOBS`, `COST_W`, `IDX_W`=3, the state enum (`IDLE`, `LOAD`, `CHECK`, `SERVE`), and the load-counter width.
- Sub-module `jam_cost_mem`: 64×`COST_W` register array with one synchronous write port (addr, data, we) and one asynchronous read port `{W,J}`. The FSM, counter and checksum logic live in the top module.

## Test plan
- Reset: drive `RST`=0 → all outputs 0. Release `RST` → `LD_READY`=0 for one cycle, then 1.
- Full load: send entry k = (k*3)%101 with `LD_VALID` held 1 → `TableReady`=1 one cycle after the 64th transfer. Then `W`=3, `J`=5 (k=29) → `Cost`=87 in the same cycle; `W`=7, `J`=7 → `Cost`=88.
- Gapped stream: toggle `LD_VALID` 1/0 every cycle over 128 cycles → exactly 64 transfers, and entries match those of the back-to-back load.
- Clear mid-load: after 20 transfers, assert `Clear` together with `LD_VALID` → that word is dropped. The next 64 words define the whole table and `TableReady` rises after them.
- Serve isolation: in `SERVE`, hold `LD_VALID`=1 with `LD_DATA`=127 for 10 cycles → `LD_READY`=0 and all 64 lookups unchanged.
- Checksum (macro on): correct 65th word → `TableReady`=1. Corrupted checksum (+1) → `LdErr`=1, `TableReady`=0, `LD_READY`=1. A reload then clears `LdErr` on its first transfer.
